ewrapper_emesh_arbiter: RTL and testbench

// - Two-requester arbiter in front of the elink transmitter's emesh_*_outb interface.
// - Lets two emesh masters (for example, host AXI bridge and DMA) share one elink TX path.
// - Per-port FIFO, round-robin grant, and per-type (write/read) backpressure from the link.
// - Overflow is detected and reported; transaction order within a port is preserved.

---
 rtl/ewrapper_emesh_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ewrapper_emesh_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ewrapper_emesh_arbiter.sv
// ewrapper_emesh_arbiter
//   Lets two emesh masters share one elink transmit path. Each master feeds
//   its own FIFO. A round-robin arbiter picks an eligible FIFO head and loads
//   it into a registered output stage that drives emesh_*_outb.
//
// Ports
//   clk, reset_n              emesh clock, asynchronous active-low reset
//   m{0,1}_access/...         transaction from master i: one-cycle access
//                             pulse with write/datamode/ctrlmode/addr/data
//   m{0,1}_wr_wait/rd_wait    registered backpressure to master i, raised
//                             when its FIFO holds FIFO_DEPTH-1 or more
//                             entries
//   emesh_*_outb              granted transaction; access strobe is one cycle
//   emesh_wr_wait_inb/rd_...  link backpressure, applied per transaction type
//   overflow[i]               sticky: an access from master i hit a full FIFO
module ewrapper_emesh_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_access,
  input  logic        m0_write,
  input  logic [1:0]  m0_datamode,
  input  logic [3:0]  m0_ctrlmode,
  input  logic [31:0] m0_dstaddr,
  input  logic [31:0] m0_srcaddr,
  input  logic [31:0] m0_data,
  output logic        m0_wr_wait,
  output logic        m0_rd_wait,
  input  logic        m1_access,
  input  logic        m1_write,
  input  logic [1:0]  m1_datamode,
  input  logic [3:0]  m1_ctrlmode,
  input  logic [31:0] m1_dstaddr,
  input  logic [31:0] m1_srcaddr,
  input  logic [31:0] m1_data,
  output logic        m1_wr_wait,
  output logic        m1_rd_wait,
  output logic        emesh_access_outb,
  output logic        emesh_write_outb,
  output logic [1:0]  emesh_datamode_outb,
  output logic [3:0]  emesh_ctrlmode_outb,
  output logic [31:0] emesh_dstaddr_outb,
  output logic [31:0] emesh_srcaddr_outb,
  output logic [31:0] emesh_data_outb,
  input  logic        emesh_wr_wait_inb,
  input  logic        emesh_rd_wait_inb,
  output logic [1:0]  overflow
);

  typedef struct packed {
    logic        write;
    logic [1:0]  datamode;
    logic [3:0]  ctrlmode;
    logic [31:0] dstaddr;
    logic [31:0] srcaddr;
    logic [31:0] data;
  } pkt_t;

  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0] CNT_HIGH = (FIFO_AW+1)'(FIFO_DEPTH - 1);

  logic [1:0]         in_acc;
  pkt_t               in_pkt   [2];
  pkt_t               mem_q    [2][FIFO_DEPTH];
  pkt_t               head     [2];
  logic [FIFO_AW-1:0] wr_ptr_q [2];
  logic [FIFO_AW-1:0] wr_ptr_d [2];
  logic [FIFO_AW-1:0] rd_ptr_q [2];
  logic [FIFO_AW-1:0] rd_ptr_d [2];
  logic [FIFO_AW:0]   count_q  [2];
  logic [FIFO_AW:0]   count_d  [2];
  logic [1:0]         push, pop, elig;
  logic [1:0]         wait_q, wait_d;
  logic [1:0]         ovf_q, ovf_d;
  logic               gnt_any, gnt_port;
  logic               rr_q, rr_d;
  logic               acc_q, acc_d;
  pkt_t               out_q, out_d;

  always_comb begin
    in_acc    = {m1_access, m0_access};
    in_pkt[0] = {m0_write, m0_datamode, m0_ctrlmode, m0_dstaddr, m0_srcaddr, m0_data};
    in_pkt[1] = {m1_write, m1_datamode, m1_ctrlmode, m1_dstaddr, m1_srcaddr, m1_data};
  end

  // NOTE: every signal written here gets a value before any condition so no
  // path leaves it unassigned; otherwise a latch would be inferred.
  always_comb begin
    elig = '0;
    push = '0;
    pop  = '0;
    for (int i = 0; i < 2; i++) begin
      head[i] = mem_q[i][rd_ptr_q[i]];
      // Only the head may go: a blocked head holds back everything behind it.
      elig[i] = (count_q[i] != '0) &&
                !(head[i].write ? emesh_wr_wait_inb : emesh_rd_wait_inb);
      // A full FIFO drops the access even if it pops this cycle.
      push[i] = in_acc[i] && (count_q[i] != CNT_FULL);
    end

    gnt_any  = |elig;
    gnt_port = (&elig) ? rr_q : elig[1];
    if (gnt_any) pop[gnt_port] = 1'b1;

    for (int i = 0; i < 2; i++) begin
      count_d[i]  = count_q[i] + (FIFO_AW+1)'(push[i]) - (FIFO_AW+1)'(pop[i]);
      wr_ptr_d[i] = wr_ptr_q[i] + FIFO_AW'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + FIFO_AW'(pop[i]);
      // Raised one entry early so a master that reacts a cycle late still fits.
      wait_d[i]   = (count_d[i] >= CNT_HIGH);
    end

    ovf_d = ovf_q | (in_acc & ~push);
    acc_d = gnt_any;
    out_d = gnt_any ? head[gnt_port] : out_q;
    rr_d  = gnt_any ? ~gnt_port : rr_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      wait_q <= '0;
      ovf_q  <= '0;
      rr_q   <= 1'b0;
      acc_q  <= 1'b0;
      out_q  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      wait_q <= wait_d;
      ovf_q  <= ovf_d;
      rr_q   <= rr_d;
      acc_q  <= acc_d;
      out_q  <= out_d;
    end
  end

  // NOTE: FIFO storage has no reset; the emptied pointers/counts make stale
  // contents unreachable, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_pkt[i];
    end
  end

  assign m0_wr_wait          = wait_q[0];
  assign m0_rd_wait          = wait_q[0];
  assign m1_wr_wait          = wait_q[1];
  assign m1_rd_wait          = wait_q[1];
  assign overflow            = ovf_q;
  assign emesh_access_outb   = acc_q;
  assign emesh_write_outb    = out_q.write;
  assign emesh_datamode_outb = out_q.datamode;
  assign emesh_ctrlmode_outb = out_q.ctrlmode;
  assign emesh_dstaddr_outb  = out_q.dstaddr;
  assign emesh_srcaddr_outb  = out_q.srcaddr;
  assign emesh_data_outb     = out_q.data;

endmodule

// File: tb/tb_ewrapper_emesh_arbiter.sv
// Testbench for ewrapper_emesh_arbiter: directed scenarios followed by a
// randomized phase, all checked against a queue-based reference model.
module tb_ewrapper_emesh_arbiter;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic        write;
    logic [1:0]  datamode;
    logic [3:0]  ctrlmode;
    logic [31:0] dstaddr;
    logic [31:0] srcaddr;
    logic [31:0] data;
  } pkt_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic acc0 = 1'b0, acc1 = 1'b0, lwr = 1'b0, lrd = 1'b0;
  pkt_t in0 = '0, in1 = '0;

  logic        m0_wr_wait, m0_rd_wait, m1_wr_wait, m1_rd_wait;
  logic        emesh_access_outb, emesh_write_outb;
  logic [1:0]  emesh_datamode_outb, overflow;
  logic [3:0]  emesh_ctrlmode_outb;
  logic [31:0] emesh_dstaddr_outb, emesh_srcaddr_outb, emesh_data_outb;
  pkt_t        out_pkt;

  always #5 clk = ~clk;

  assign out_pkt = {emesh_write_outb, emesh_datamode_outb, emesh_ctrlmode_outb,
                    emesh_dstaddr_outb, emesh_srcaddr_outb, emesh_data_outb};

  ewrapper_emesh_arbiter #(.FIFO_DEPTH(DEPTH), .FIFO_AW(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_access(acc0), .m0_write(in0.write), .m0_datamode(in0.datamode),
    .m0_ctrlmode(in0.ctrlmode), .m0_dstaddr(in0.dstaddr),
    .m0_srcaddr(in0.srcaddr), .m0_data(in0.data),
    .m0_wr_wait(m0_wr_wait), .m0_rd_wait(m0_rd_wait),
    .m1_access(acc1), .m1_write(in1.write), .m1_datamode(in1.datamode),
    .m1_ctrlmode(in1.ctrlmode), .m1_dstaddr(in1.dstaddr),
    .m1_srcaddr(in1.srcaddr), .m1_data(in1.data),
    .m1_wr_wait(m1_wr_wait), .m1_rd_wait(m1_rd_wait),
    .emesh_access_outb(emesh_access_outb), .emesh_write_outb(emesh_write_outb),
    .emesh_datamode_outb(emesh_datamode_outb),
    .emesh_ctrlmode_outb(emesh_ctrlmode_outb),
    .emesh_dstaddr_outb(emesh_dstaddr_outb),
    .emesh_srcaddr_outb(emesh_srcaddr_outb), .emesh_data_outb(emesh_data_outb),
    .emesh_wr_wait_inb(lwr), .emesh_rd_wait_inb(lrd), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per master, a round-robin bit, expected outputs.
  pkt_t       mq0[$], mq1[$], obs_log[$];
  logic       exp_acc = 1'b0, m_rr = 1'b0;
  pkt_t       exp_pkt = '0;
  logic [1:0] exp_wait = '0, exp_ovf = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    exp_acc  = 1'b0;
    exp_pkt  = '0;
    exp_wait = '0;
    exp_ovf  = '0;
    m_rr     = 1'b0;
  endtask

  // One clock edge of the model, using the inputs the DUT sampled at that edge.
  task automatic model_edge(input logic a0, input logic a1, input pkt_t c0,
                            input pkt_t c1, input logic w, input logic r);
    logic e0, e1, g, f0, f1;
    f0 = (mq0.size() == DEPTH);
    f1 = (mq1.size() == DEPTH);
    e0 = 1'b0;
    e1 = 1'b0;
    if (mq0.size() != 0) e0 = !(mq0[0].write ? w : r);
    if (mq1.size() != 0) e1 = !(mq1[0].write ? w : r);
    g = (e0 && e1) ? m_rr : e1;
    exp_acc = e0 | e1;
    if (exp_acc) begin
      if (g) exp_pkt = mq1.pop_front();
      else   exp_pkt = mq0.pop_front();
      m_rr = !g;
    end
    if (a0) begin
      if (f0) exp_ovf[0] = 1'b1;
      else    mq0.push_back(c0);
    end
    if (a1) begin
      if (f1) exp_ovf[1] = 1'b1;
      else    mq1.push_back(c1);
    end
    exp_wait[0] = (mq0.size() >= DEPTH - 1);
    exp_wait[1] = (mq1.size() >= DEPTH - 1);
  endtask

  // Advance one clock, update the model, compare 1 time unit after the edge.
  task automatic step();
    pkt_t c0, c1;
    logic a0, a1, w, r;
    c0 = in0; c1 = in1; a0 = acc0; a1 = acc1; w = lwr; r = lrd;
    @(posedge clk);
    model_edge(a0, a1, c0, c1, w, r);
    #1;
    check("access", 128'(emesh_access_outb), 128'(exp_acc));
    if (exp_acc) check("packet", 128'(out_pkt), 128'(exp_pkt));
    check("m0_wr_wait", 128'(m0_wr_wait), 128'(exp_wait[0]));
    check("m0_rd_wait", 128'(m0_rd_wait), 128'(exp_wait[0]));
    check("m1_wr_wait", 128'(m1_wr_wait), 128'(exp_wait[1]));
    check("m1_rd_wait", 128'(m1_rd_wait), 128'(exp_wait[1]));
    check("overflow", 128'(overflow), 128'(exp_ovf));
    if (emesh_access_outb) obs_log.push_back(out_pkt);
  endtask

  task automatic idle();
    acc0 = 1'b0;
    acc1 = 1'b0;
  endtask

  // data carries {port, seq} so emitted packets can be traced to their source.
  function automatic pkt_t mk(input bit port, input bit wr, input int seq);
    pkt_t p;
    p.write    = wr;
    p.datamode = 2'($urandom);
    p.ctrlmode = 4'($urandom);
    p.dstaddr  = $urandom;
    p.srcaddr  = $urandom;
    p.data     = {15'd0, port, seq[15:0]};
    return p;
  endfunction

  function automatic int cnt_port(input bit port);
    int n = 0;
    foreach (obs_log[j]) if (obs_log[j].data[16] == port) n++;
    return n;
  endfunction

  initial begin
    int n0, n1, k;
    logic saw_wait;

    // ---- Reset state
    model_reset();
    #12;
    check("rst_access", 128'(emesh_access_outb), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    check("rst_waits", 128'({m0_wr_wait, m0_rd_wait, m1_wr_wait, m1_rd_wait}), 128'(0));
    check("rst_fields", 128'(out_pkt), 128'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // ---- Single write: two-edge latency, one-cycle strobe
    in0 = mk(0, 1, 0);
    in0.dstaddr = 32'h8080_0000;
    in0.data    = 32'h1234_5678;
    acc0 = 1'b1;
    step();
    check("single_not_early", 128'(emesh_access_outb), 128'(0));
    idle();
    step();
    check("single_strobe", 128'(emesh_access_outb), 128'(1));
    check("single_dst", 128'(emesh_dstaddr_outb), 128'(32'h8080_0000));
    check("single_data", 128'(emesh_data_outb), 128'(32'h1234_5678));
    check("single_write", 128'(emesh_write_outb), 128'(1));
    step();
    check("single_one_cycle", 128'(emesh_access_outb), 128'(0));
    check("single_ovf", 128'(overflow), 128'(0));

    // One m1 transaction so the pointer favours m0 next.
    in1 = mk(1, 1, 0);
    acc1 = 1'b1;
    step();
    idle();
    for (int i = 0; i < 3; i++) step();

    // ---- Contention: both masters, four writes each, same start cycle
    obs_log.delete();
    for (int i = 0; i < 4; i++) begin
      in0 = mk(0, 1, i);
      in1 = mk(1, 1, i);
      acc0 = 1'b1;
      acc1 = 1'b1;
      step();
    end
    idle();
    for (int i = 0; i < 8; i++) step();
    check("cont_count", 128'(obs_log.size()), 128'(8));
    for (int j = 0; j < 8 && j < obs_log.size(); j++) begin
      check("cont_port", 128'(obs_log[j].data[16]), 128'(j % 2));
      check("cont_seq", 128'(obs_log[j].data[15:0]), 128'(j / 2));
    end
    check("cont_ovf", 128'(overflow), 128'(0));

    // ---- Type backpressure: writes blocked, reads flow
    obs_log.delete();
    lwr = 1'b1;
    n0 = 0;
    n1 = 0;
    saw_wait = 1'b0;
    for (int c = 0; c < 20; c++) begin
      acc0 = !m0_wr_wait;
      if (acc0) begin
        in0 = mk(0, 1, n0);
        n0++;
      end
      acc1 = !m1_rd_wait;
      in1 = mk(1, 0, n1);
      n1++;
      step();
      if (m0_wr_wait) saw_wait = 1'b1;
    end
    idle();
    check("bp_wait_seen", 128'(saw_wait), 128'(1));
    check("bp_m0_pushed", 128'(n0), 128'(3));
    check("bp_m0_stalled", 128'(cnt_port(0)), 128'(0));
    check("bp_m1_flowed", 128'(cnt_port(1) > 0), 128'(1));
    obs_log.delete();
    lwr = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("bp_drain_count", 128'(cnt_port(0)), 128'(3));
    k = 0;
    foreach (obs_log[j]) if (obs_log[j].data[16] == 1'b0) begin
      check("bp_drain_order", 128'(obs_log[j].data[15:0]), 128'(k));
      k++;
    end

    // ---- Head-of-line: m0 read blocks the m0 write behind it
    obs_log.delete();
    lrd = 1'b1;
    in0 = mk(0, 0, 100);
    in1 = mk(1, 1, 100);
    acc0 = 1'b1;
    acc1 = 1'b1;
    step();
    in0 = mk(0, 1, 101);
    in1 = mk(1, 1, 101);
    step();
    idle();
    for (int i = 0; i < 4; i++) step();
    check("hol_m0_blocked", 128'(cnt_port(0)), 128'(0));
    check("hol_m1_served", 128'(cnt_port(1)), 128'(2));
    obs_log.delete();
    lrd = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("hol_release_count", 128'(obs_log.size()), 128'(2));
    if (obs_log.size() == 2) begin
      check("hol_first_read", 128'({obs_log[0].write, obs_log[0].data[15:0]}), 128'({1'b0, 16'd100}));
      check("hol_then_write", 128'({obs_log[1].write, obs_log[1].data[15:0]}), 128'({1'b1, 16'd101}));
    end

    // ---- Overflow: m1 ignores its wait and pushes five writes
    obs_log.delete();
    lwr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in1 = mk(1, 1, 200 + i);
      acc1 = 1'b1;
      step();
    end
    idle();
    step();
    check("ovf_set", 128'(overflow), 128'(2'b10));
    check("ovf_nothing_out", 128'(obs_log.size()), 128'(0));
    lwr = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("ovf_four_out", 128'(cnt_port(1)), 128'(4));
    foreach (obs_log[j]) check("ovf_order", 128'(obs_log[j].data[15:0]), 128'(200 + j));
    check("ovf_sticky", 128'(overflow), 128'(2'b10));

    // ---- Randomized traffic; masters mostly respect their waits
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 400; c++) begin
      lwr  = ($urandom_range(0, 3) == 0);
      lrd  = ($urandom_range(0, 3) == 0);
      acc0 = ($urandom_range(0, 1) == 1) && (!m0_wr_wait || $urandom_range(0, 15) == 0);
      acc1 = ($urandom_range(0, 1) == 1) && (!m1_wr_wait || $urandom_range(0, 15) == 0);
      in0 = mk(0, 1'($urandom), n0);
      in1 = mk(1, 1'($urandom), n1);
      n0++;
      n1++;
      step();
    end
    lwr = 1'b0;
    lrd = 1'b0;

    // ---- Reset in the middle of a burst
    for (int i = 0; i < 3; i++) begin
      in0 = mk(0, 1, 500 + i);
      in1 = mk(1, 1, 500 + i);
      acc0 = 1'b1;
      acc1 = 1'b1;
      step();
    end
    #2 reset_n = 1'b0;
    #1;
    check("midrst_access", 128'(emesh_access_outb), 128'(0));
    check("midrst_fields", 128'(out_pkt), 128'(0));
    check("midrst_overflow", 128'(overflow), 128'(0));
    check("midrst_waits", 128'({m0_wr_wait, m1_wr_wait}), 128'(0));
    model_reset();
    idle();
    @(posedge clk);
    #1 reset_n = 1'b1;

    // rr back at 0: simultaneous pushes come out m0 first.
    obs_log.delete();
    in0 = mk(0, 1, 300);
    in1 = mk(1, 1, 300);
    acc0 = 1'b1;
    acc1 = 1'b1;
    step();
    idle();
    step();
    check("post_rst_m0_first", 128'({emesh_access_outb, emesh_data_outb[16]}), 128'(2'b10));
    step();
    check("post_rst_m1_second", 128'({emesh_access_outb, emesh_data_outb[16]}), 128'(2'b11));
    step();
    step();
    in1 = mk(1, 0, 301);
    acc1 = 1'b1;
    step();
    check("post_rst_m1_not_early", 128'(emesh_access_outb), 128'(0));
    idle();
    step();
    check("post_rst_m1_out", 128'({emesh_access_outb, emesh_data_outb}), 128'({1'b1, 32'h0001_012D}));
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
